// File: rtl/match_sequencer.sv
// Round scheduler for two fighters: attract, countdown, fight, respawn, game over; stocks/invuln/winner.
// Latency: every output registered, changes 1 cycle after the triggering edge/tick; no backpressure.
module match_sequencer #(
    parameter int NUM_STOCKS       = 3,
    parameter int FRAMES_PER_DIGIT = 60,
    parameter int RESPAWN_FRAMES   = 90,
    parameter int INVULN_FRAMES    = 120,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_rate,
    input  logic       start_btn,
    input  logic       ko_p1,
    input  logic       ko_p2,
    output logic [2:0] game_state,
    output logic       fighters_reset,
    output logic       respawn_p1,
    output logic       respawn_p2,
    output logic       input_enable,
    output logic       invuln_p1,
    output logic       invuln_p2,
    output logic [1:0] stocks_p1,
    output logic [1:0] stocks_p2,
    output logic [1:0] countdown_digit,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_ATTRACT   = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_RESPAWN   = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               fighters_reset_q, fighters_reset_d;
    logic               respawn_p1_q, respawn_p1_d;
    logic               respawn_p2_q, respawn_p2_d;
    logic               input_enable_q, input_enable_d;
    logic               invuln_p1_q, invuln_p1_d;
    logic               invuln_p2_q, invuln_p2_d;
    logic [1:0]         stocks_p1_q, stocks_p1_d;
    logic [1:0]         stocks_p2_q, stocks_p2_d;
    logic [1:0]         digit_q, digit_d;
    logic [1:0]         winner_q, winner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   inv_cnt_p1_q, inv_cnt_p1_d;
    logic [CNT_W-1:0]   inv_cnt_p2_q, inv_cnt_p2_d;
    logic               ko_lat_p1_q, ko_lat_p1_d;
    logic               ko_lat_p2_q, ko_lat_p2_d;
    logic               start_prev_q, start_prev_d;

    logic               start_edge;
    logic               ko_eff_p1, ko_eff_p2;
    logic               hit_p1, hit_p2, any_hit, match_over;
    logic [1:0]         stock_nx_p1, stock_nx_p2;
    logic               cd_wrap, rs_done;

    assign start_edge  = start_btn & ~start_prev_q;
    // A KO arriving while invulnerable is discarded, never latched.
    assign ko_eff_p1   = ko_p1 & ~invuln_p1_q;
    assign ko_eff_p2   = ko_p2 & ~invuln_p2_q;
    assign hit_p1      = (state_q == S_FIGHT) & frame_rate & (ko_lat_p1_q | ko_eff_p1);
    assign hit_p2      = (state_q == S_FIGHT) & frame_rate & (ko_lat_p2_q | ko_eff_p2);
    assign stock_nx_p1 = (hit_p1 && stocks_p1_q != 2'd0) ? stocks_p1_q - 2'd1 : stocks_p1_q;
    assign stock_nx_p2 = (hit_p2 && stocks_p2_q != 2'd0) ? stocks_p2_q - 2'd1 : stocks_p2_q;
    assign any_hit     = hit_p1 | hit_p2;
    assign match_over  = any_hit & ((stock_nx_p1 == 2'd0) | (stock_nx_p2 == 2'd0));
    assign cd_wrap     = (cnt_q == CNT_W'(FRAMES_PER_DIGIT - 1));
    assign rs_done     = (cnt_q == CNT_W'(RESPAWN_FRAMES - 1));
    assign start_prev_d = start_btn;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_ATTRACT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ATTRACT:   if (start_edge) state_d = S_COUNTDOWN;
            S_COUNTDOWN: if (frame_rate && cd_wrap && digit_q == 2'd1) state_d = S_FIGHT;
            S_FIGHT: begin
                if (match_over)   state_d = S_GAME_OVER;
                else if (any_hit) state_d = S_RESPAWN;
            end
            S_RESPAWN:   if (frame_rate && rs_done) state_d = S_FIGHT;
            S_GAME_OVER: if (start_edge) state_d = S_ATTRACT;
            default:     state_d = S_ATTRACT;
        endcase
    end

    always_comb begin
        fighters_reset_d = fighters_reset_q;
        respawn_p1_d     = respawn_p1_q;
        respawn_p2_d     = respawn_p2_q;
        input_enable_d   = input_enable_q;
        invuln_p1_d      = invuln_p1_q;
        invuln_p2_d      = invuln_p2_q;
        stocks_p1_d      = stocks_p1_q;
        stocks_p2_d      = stocks_p2_q;
        digit_d          = digit_q;
        winner_d         = winner_q;
        cnt_d            = cnt_q;
        inv_cnt_p1_d     = inv_cnt_p1_q;
        inv_cnt_p2_d     = inv_cnt_p2_q;
        ko_lat_p1_d      = 1'b0;
        ko_lat_p2_d      = 1'b0;
        case (state_q)
            S_ATTRACT: begin
                fighters_reset_d = 1'b1;
                input_enable_d   = 1'b0;
                if (start_edge) begin
                    stocks_p1_d  = 2'(NUM_STOCKS);
                    stocks_p2_d  = 2'(NUM_STOCKS);
                    winner_d     = 2'b00;
                    invuln_p1_d  = 1'b0;
                    invuln_p2_d  = 1'b0;
                    inv_cnt_p1_d = '0;
                    inv_cnt_p2_d = '0;
                    digit_d      = 2'd3;
                    cnt_d        = '0;
                end
            end
            S_COUNTDOWN: begin
                if (frame_rate) begin
                    if (cd_wrap) begin
                        cnt_d = '0;
                        if (digit_q == 2'd1) begin
                            digit_d          = 2'd0;
                            fighters_reset_d = 1'b0;
                            input_enable_d   = 1'b1;
                        end else begin
                            digit_d = digit_q - 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIGHT: begin
                ko_lat_p1_d = ko_lat_p1_q | ko_eff_p1;
                ko_lat_p2_d = ko_lat_p2_q | ko_eff_p2;
                if (frame_rate && invuln_p1_q) begin
                    inv_cnt_p1_d = inv_cnt_p1_q - 1'b1;
                    if (inv_cnt_p1_q == CNT_W'(1)) invuln_p1_d = 1'b0;
                end
                if (frame_rate && invuln_p2_q) begin
                    inv_cnt_p2_d = inv_cnt_p2_q - 1'b1;
                    if (inv_cnt_p2_q == CNT_W'(1)) invuln_p2_d = 1'b0;
                end
                if (hit_p1) begin
                    stocks_p1_d  = stock_nx_p1;
                    ko_lat_p1_d  = 1'b0;
                    invuln_p1_d  = 1'b0;
                    inv_cnt_p1_d = '0;
                end
                if (hit_p2) begin
                    stocks_p2_d  = stock_nx_p2;
                    ko_lat_p2_d  = 1'b0;
                    invuln_p2_d  = 1'b0;
                    inv_cnt_p2_d = '0;
                end
                if (match_over) begin
                    input_enable_d = 1'b0;
                    // bit1 set when P1 is out, bit0 when P2 is out; both = draw
                    winner_d = {stock_nx_p1 == 2'd0, stock_nx_p2 == 2'd0};
                end else if (any_hit) begin
                    input_enable_d = 1'b0;
                    cnt_d          = '0;
                    respawn_p1_d   = hit_p1;
                    respawn_p2_d   = hit_p2;
                end
            end
            S_RESPAWN: begin
                if (frame_rate) begin
                    if (rs_done) begin
                        cnt_d          = '0;
                        input_enable_d = 1'b1;
                        respawn_p1_d   = 1'b0;
                        respawn_p2_d   = 1'b0;
                        if (respawn_p1_q) begin
                            invuln_p1_d  = 1'b1;
                            inv_cnt_p1_d = CNT_W'(INVULN_FRAMES);
                        end
                        if (respawn_p2_q) begin
                            invuln_p2_d  = 1'b1;
                            inv_cnt_p2_d = CNT_W'(INVULN_FRAMES);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                input_enable_d = 1'b0;
                if (start_edge) fighters_reset_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fighters_reset_q <= 1'b1;
            respawn_p1_q     <= 1'b0;
            respawn_p2_q     <= 1'b0;
            input_enable_q   <= 1'b0;
            invuln_p1_q      <= 1'b0;
            invuln_p2_q      <= 1'b0;
            stocks_p1_q      <= 2'(NUM_STOCKS);
            stocks_p2_q      <= 2'(NUM_STOCKS);
            digit_q          <= 2'd0;
            winner_q         <= 2'b00;
            cnt_q            <= '0;
            inv_cnt_p1_q     <= '0;
            inv_cnt_p2_q     <= '0;
            ko_lat_p1_q      <= 1'b0;
            ko_lat_p2_q      <= 1'b0;
            start_prev_q     <= 1'b0;
        end else begin
            fighters_reset_q <= fighters_reset_d;
            respawn_p1_q     <= respawn_p1_d;
            respawn_p2_q     <= respawn_p2_d;
            input_enable_q   <= input_enable_d;
            invuln_p1_q      <= invuln_p1_d;
            invuln_p2_q      <= invuln_p2_d;
            stocks_p1_q      <= stocks_p1_d;
            stocks_p2_q      <= stocks_p2_d;
            digit_q          <= digit_d;
            winner_q         <= winner_d;
            cnt_q            <= cnt_d;
            inv_cnt_p1_q     <= inv_cnt_p1_d;
            inv_cnt_p2_q     <= inv_cnt_p2_d;
            ko_lat_p1_q      <= ko_lat_p1_d;
            ko_lat_p2_q      <= ko_lat_p2_d;
            start_prev_q     <= start_prev_d;
        end
    end

    assign game_state      = state_q;
    assign fighters_reset  = fighters_reset_q;
    assign respawn_p1      = respawn_p1_q;
    assign respawn_p2      = respawn_p2_q;
    assign input_enable    = input_enable_q;
    assign invuln_p1       = invuln_p1_q;
    assign invuln_p2       = invuln_p2_q;
    assign stocks_p1       = stocks_p1_q;
    assign stocks_p2       = stocks_p2_q;
    assign countdown_digit = digit_q;
    assign winner          = winner_q;

endmodule
